m68k_bus_responder: RTL and testbench
=====================================

# m68k_bus_responder

Bus-cycle responder for one 68000 (main or sound CPU): the other end of the address decoder. It takes the region selects the decoder produces and answers the CPU's address strobe. Fast (block-RAM / register) regions get a fixed wait count. ROM reads are fetched over a req/ack handshake to the SDRAM controller. The block drives DTACK and the read-data mux back to the CPU. One instance sits beside each CPU core.

## Interface
- FAST_WAIT, 1: extra clocks between strobe detection and DTACK for fast regions (0–15).
- TIMEOUT, 255: clocks a slow (SDRAM) cycle may wait for ack before a forced open-bus response (1–255).
- clk  in  1  system clock; the only clock.
- reset  in  1  asynchronous, active-high reset.
- as_n  in  1  CPU address strobe, active low.
- rw  in  1  1 = read, 0 = write.
- fast_cs  in  1  OR of all on-chip region selects from the decoder.
- slow_cs  in  1  ROM select (SDRAM-backed).
- fast_data  in  16  read data from the on-chip read mux.
- sdr_ack  in  1  single-cycle ack from SDRAM controller; data valid same cycle.
- sdr_data  in  16  SDRAM read data.
- sdr_req  out  1  SDRAM read request; level, held until ack.
- dtack_n  out  1  data acknowledge to CPU, active low.
- cpu_din  out  16  registered read data to CPU.
- timeout  out  1  one-cycle pulse when a slow cycle is force-terminated.

## Operation
- The block registers as_n into as_q. A new cycle starts on the edge where as_q=1 and as_n=0 (start edge). The cs inputs and rw are sampled only on that edge.
- States: IDLE, FAST, SLOW, HOLD, DRAIN.
- IDLE, start edge:
  - slow_cs=1 and rw=1 → SLOW. sdr_req=1, to=0.
  - Otherwise → FAST with cnt=FAST_WAIT. This covers fast_cs, ROM writes, and unmapped accesses.
  - If slow_cs and fast_cs are both high, slow_cs has priority.
- FAST:
  - cnt≠0: decrement.
  - cnt=0: cpu_din←fast_data if fast_cs was sampled, else 16'hFFFF (open bus). Set dtack_n=0 → HOLD.
- SLOW: to increments each cycle.
  - sdr_ack=1: cpu_din←sdr_data, sdr_req=0, dtack_n=0 → HOLD.
  - Else, to=TIMEOUT: cpu_din←16'hFFFF, sdr_req=0, dtack_n=0, timeout=1 → HOLD.
- HOLD: dtack_n stays 0 while as_n=0. On as_n=1: dtack_n=1 → IDLE. cpu_din holds its value.
- Abort (as_n=1 before DTACK):
  - From FAST → IDLE, no DTACK.
  - From SLOW → DRAIN, sdr_req kept high. The SDRAM transaction must complete.
- DRAIN: on sdr_ack, sdr_req=0 → IDLE. A start edge arriving in DRAIN is not lost: the block latches it and processes it on the cycle after the ack.
- Reset values: state IDLE, dtack_n=1, sdr_req=0, cpu_din=16'h0000, timeout=0, cnt=0, to=0, as_q=1.
- Reset asserted mid-cycle returns all outputs to reset values immediately. A pending SDRAM request is dropped, and the SDRAM controller is reset by the same signal.
- sdr_ack outside SLOW/DRAIN is ignored.

## Timing
- Edge E0 = the start edge.
- Fast cycle: dtack_n falls on edge E0+FAST_WAIT+1. With FAST_WAIT=0, dtack_n falls on E0+1.
- Slow cycle: sdr_req rises on E0. dtack_n falls on the edge that samples sdr_ack=1, which is zero additional latency after ack.
- Timeout: dtack_n falls on edge E0+TIMEOUT. timeout is high for exactly that cycle.
- Release: dtack_n rises on the first edge that samples as_n=1 in HOLD.
- The earliest next start edge is the following edge. Back-to-back cycles need as_n high for at least one sampled clock.
- cpu_din is stable from the dtack_n fall until the next dtack_n fall.

## Structure
- Shared package holds:
  - the state enum (IDLE, FAST, SLOW, HOLD, DRAIN);
  - OPEN_BUS = 16'hFFFF;
  - the wait-counter width (4) and timeout-counter width (8).
- No sub-module. The FSM, edge detect and both counters stay in one always block plus output registers, at roughly 150–250 lines.

## Test plan
- Fast read, FAST_WAIT=1, fast_data=16'h1234: start at E0 → dtack_n low at E0+2, cpu_din=1234. as_n high → dtack_n high next edge.
- ROM read, ack 5 clocks after req with sdr_data=16'hBEEF: sdr_req high E0..E0+5, dtack_n low at E0+5, cpu_din=BEEF, exactly one request.
- ROM read with no ack, TIMEOUT=8: dtack_n low at E0+8, cpu_din=FFFF, timeout pulse 1 cycle, sdr_req low from E0+8.
- Abort: as_n high at E0+2 during SLOW, ack at E0+6. The bus must show no DTACK and sdr_req high until E0+6. A new fast cycle started at E0+4 must complete after drain with correct data.
- Unmapped read (both cs=0) and ROM write (slow_cs=1, rw=0): DTACK at E0+FAST_WAIT+1, cpu_din=FFFF for the read, sdr_req never asserts.
- Reset pulsed in SLOW at E0+3: dtack_n=1, sdr_req=0, cpu_din=0000 asynchronously. A subsequent fast read behaves as in the first case.

Source files
------------

// File: rtl/m68k_bus_responder_pkg.sv
// Shared types and constants for the 68000 bus-cycle responder.
package m68k_bus_responder_pkg;

    localparam int DATA_W = 16;
    localparam int WAIT_W = 4;
    localparam int TO_W   = 8;

    // Value returned when nothing on the bus drives the data lines.
    localparam logic [DATA_W-1:0] OPEN_BUS = 16'hFFFF;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FAST  = 3'd1,
        ST_SLOW  = 3'd2,
        ST_HOLD  = 3'd3,
        ST_DRAIN = 3'd4
    } state_t;

endpackage

// File: rtl/m68k_bus_responder.sv
// Bus-cycle responder for one 68000: answers AS with DTACK after a fixed wait
// for on-chip regions, or after an SDRAM req/ack handshake for ROM reads.
module m68k_bus_responder
    import m68k_bus_responder_pkg::*;
#(
    parameter int FAST_WAIT = 1,
    parameter int TIMEOUT   = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              as_n,
    input  logic              rw,
    input  logic              fast_cs,
    input  logic              slow_cs,
    input  logic [DATA_W-1:0] fast_data,
    input  logic              sdr_ack,
    input  logic [DATA_W-1:0] sdr_data,
    output logic              sdr_req,
    output logic              dtack_n,
    output logic [DATA_W-1:0] cpu_din,
    output logic              timeout
);

    localparam logic [WAIT_W-1:0] FAST_WAIT_C = WAIT_W'(FAST_WAIT);
    localparam logic [TO_W-1:0]   TIMEOUT_C   = TO_W'(TIMEOUT);

    state_t              state_q, state_d;
    logic                as_q, as_d;
    logic [WAIT_W-1:0]   cnt_q, cnt_d;
    logic [TO_W-1:0]     to_q, to_d;
    logic                fast_sel_q, fast_sel_d;
    logic                pend_q, pend_d;
    logic                pend_slow_q, pend_slow_d;
    logic                pend_fast_q, pend_fast_d;
    logic                sdr_req_q, sdr_req_d;
    logic                dtack_n_q, dtack_n_d;
    logic [DATA_W-1:0]   cpu_din_q, cpu_din_d;
    logic                timeout_q, timeout_d;

    logic                start;
    logic                go_slow;
    logic                go_fast_sel;

    // Falling edge of the address strobe, seen against last cycle's sample.
    assign start = as_q & ~as_n;

    // Next-state logic for the cycle FSM, both counters and the output registers.
    always_comb begin
        state_d     = state_q;
        as_d        = as_n;
        cnt_d       = cnt_q;
        to_d        = to_q;
        fast_sel_d  = fast_sel_q;
        pend_d      = pend_q;
        pend_slow_d = pend_slow_q;
        pend_fast_d = pend_fast_q;
        sdr_req_d   = sdr_req_q;
        dtack_n_d   = dtack_n_q;
        cpu_din_d   = cpu_din_q;
        timeout_d   = 1'b0;
        go_slow     = 1'b0;
        go_fast_sel = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // A start latched during DRAIN is served before any new one.
                if (start || pend_q) begin
                    go_slow     = pend_q ? pend_slow_q : (slow_cs & rw);
                    go_fast_sel = pend_q ? pend_fast_q : fast_cs;
                    pend_d      = 1'b0;
                    if (go_slow) begin
                        state_d   = ST_SLOW;
                        sdr_req_d = 1'b1;
                        to_d      = '0;
                    end else begin
                        state_d    = ST_FAST;
                        cnt_d      = FAST_WAIT_C;
                        fast_sel_d = go_fast_sel;
                    end
                end
            end

            ST_FAST: begin
                if (as_n) begin
                    state_d = ST_IDLE;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    cpu_din_d = fast_sel_q ? fast_data : OPEN_BUS;
                    dtack_n_d = 1'b0;
                    state_d   = ST_HOLD;
                end
            end

            ST_SLOW: begin
                to_d = to_q + 1'b1;
                if (as_n) begin
                    // CPU gave up; the SDRAM access still has to finish.
                    if (sdr_ack) begin
                        sdr_req_d = 1'b0;
                        state_d   = ST_IDLE;
                    end else begin
                        state_d = ST_DRAIN;
                    end
                end else if (sdr_ack) begin
                    cpu_din_d = sdr_data;
                    sdr_req_d = 1'b0;
                    dtack_n_d = 1'b0;
                    state_d   = ST_HOLD;
                end else if (to_d == TIMEOUT_C) begin
                    cpu_din_d = OPEN_BUS;
                    sdr_req_d = 1'b0;
                    dtack_n_d = 1'b0;
                    timeout_d = 1'b1;
                    state_d   = ST_HOLD;
                end
            end

            ST_HOLD: begin
                if (as_n) begin
                    dtack_n_d = 1'b1;
                    state_d   = ST_IDLE;
                end
            end

            ST_DRAIN: begin
                if (start) begin
                    pend_d      = 1'b1;
                    pend_slow_d = slow_cs & rw;
                    pend_fast_d = fast_cs;
                end
                if (sdr_ack) begin
                    sdr_req_d = 1'b0;
                    state_d   = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset drops any pending SDRAM request.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            as_q        <= 1'b1;
            cnt_q       <= '0;
            to_q        <= '0;
            fast_sel_q  <= 1'b0;
            pend_q      <= 1'b0;
            pend_slow_q <= 1'b0;
            pend_fast_q <= 1'b0;
            sdr_req_q   <= 1'b0;
            dtack_n_q   <= 1'b1;
            cpu_din_q   <= '0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            as_q        <= as_d;
            cnt_q       <= cnt_d;
            to_q        <= to_d;
            fast_sel_q  <= fast_sel_d;
            pend_q      <= pend_d;
            pend_slow_q <= pend_slow_d;
            pend_fast_q <= pend_fast_d;
            sdr_req_q   <= sdr_req_d;
            dtack_n_q   <= dtack_n_d;
            cpu_din_q   <= cpu_din_d;
            timeout_q   <= timeout_d;
        end
    end

    assign sdr_req = sdr_req_q;
    assign dtack_n = dtack_n_q;
    assign cpu_din = cpu_din_q;
    assign timeout = timeout_q;

endmodule

// File: tb/tb_m68k_bus_responder.sv
// Testbench for m68k_bus_responder: directed bus cycles plus random
// transactions, each compared against expectations derived from cycle timing rules.
module tb_m68k_bus_responder;

    localparam int FW  = 1;
    localparam int TO  = 8;
    localparam logic [15:0] OPEN = 16'hFFFF;

    logic        clk;
    logic        reset;
    logic        as_n;
    logic        rw;
    logic        fast_cs;
    logic        slow_cs;
    logic [15:0] fast_data;
    logic        sdr_ack;
    logic [15:0] sdr_data;
    logic        sdr_req;
    logic        dtack_n;
    logic [15:0] cpu_din;
    logic        timeout;

    int checks   = 0;
    int failures = 0;

    m68k_bus_responder #(.FAST_WAIT(FW), .TIMEOUT(TO)) dut (
        .clk       (clk),
        .reset     (reset),
        .as_n      (as_n),
        .rw        (rw),
        .fast_cs   (fast_cs),
        .slow_cs   (slow_cs),
        .fast_data (fast_data),
        .sdr_ack   (sdr_ack),
        .sdr_data  (sdr_data),
        .sdr_req   (sdr_req),
        .dtack_n   (dtack_n),
        .cpu_din   (cpu_din),
        .timeout   (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One complete CPU bus cycle. Expected timing comes from the cycle rules:
    // fast/unmapped/write -> DTACK at E0+FW+1; ROM read -> DTACK at the ack edge,
    // or at E0+TO with open bus and a timeout pulse if no ack arrives by then.
    task automatic run_txn(input string name, input bit f_cs, input bit s_cs, input bit r_w,
                           input logic [15:0] fd, input logic [15:0] sd,
                           input bit do_ack, input int ack_d, input int hold);
        bit          is_slow;
        int          exp_lat, exp_to, exp_req;
        logic [15:0] exp_data;
        int          got_lat, got_to, to_n, req_cyc, hold_bad;
        logic [15:0] got_data;

        is_slow = s_cs && r_w;
        if (is_slow) begin
            if (do_ack && ack_d <= TO) begin
                exp_lat = ack_d; exp_data = sd; exp_to = 0;
            end else begin
                exp_lat = TO; exp_data = OPEN; exp_to = 1;
            end
            exp_req = exp_lat;
        end else begin
            exp_lat = FW + 1;
            exp_data = f_cs ? fd : OPEN;
            exp_to = 0;
            exp_req = 0;
        end

        got_lat = -1; got_to = 0; to_n = -1; req_cyc = 0; hold_bad = 0;
        got_data = 16'h0;
        as_n = 1'b0; fast_cs = f_cs; slow_cs = s_cs; rw = r_w; fast_data = fd;
        sdr_ack = 1'b0;
        for (int n = 0; n < 40; n++) begin
            step();
            if (sdr_req) req_cyc++;
            if (timeout) begin got_to++; to_n = n; end
            if (!dtack_n) begin
                got_lat = n;
                got_data = cpu_din;
                sdr_ack = 1'b0;
                break;
            end
            sdr_ack = is_slow && do_ack && (n + 1 == ack_d);
            sdr_data = sdr_ack ? sd : 16'($urandom);
        end
        sdr_ack = 1'b0;

        check({name, ":lat"}, got_lat, exp_lat);
        check({name, ":data"}, got_data, exp_data);
        check({name, ":timeout_cnt"}, got_to, exp_to);
        if (exp_to != 0) check({name, ":timeout_edge"}, to_n, TO);

        // Data lines the CPU no longer looks at change; DTACK and data must hold.
        fast_data = 16'($urandom);
        for (int h = 0; h < hold; h++) begin
            step();
            if (dtack_n || cpu_din !== exp_data || timeout) hold_bad++;
            if (sdr_req) req_cyc++;
        end
        check({name, ":hold"}, hold_bad, 0);

        as_n = 1'b1;
        step();
        if (sdr_req) req_cyc++;
        check({name, ":release"}, dtack_n, 1);
        check({name, ":din_after_release"}, cpu_din, exp_data);
        check({name, ":req_cycles"}, req_cyc, exp_req);
    endtask

    task automatic abort_test();
        int early_dtack, req_hi;
        as_n = 1'b1; fast_cs = 1'b0; slow_cs = 1'b0; rw = 1'b1; sdr_ack = 1'b0;
        step();
        early_dtack = 0; req_hi = 0;
        as_n = 1'b0; slow_cs = 1'b1; rw = 1'b1; fast_cs = 1'b0;
        for (int n = 0; n < 10; n++) begin
            step();
            if (n < 9 && !dtack_n) early_dtack++;
            if (n <= 5 && sdr_req) req_hi++;
            if (n == 6) check("abort:req_low_after_ack", sdr_req, 0);
            if (n == 9) begin
                check("abort:pending_dtack", dtack_n, 0);
                check("abort:pending_data", cpu_din, 16'hA5C3);
            end
            sdr_ack = 1'b0;
            if (n + 1 == 2) as_n = 1'b1;
            if (n + 1 == 4) begin
                as_n = 1'b0; slow_cs = 1'b0; fast_cs = 1'b1; rw = 1'b1;
                fast_data = 16'hA5C3;
            end
            if (n + 1 == 6) begin
                sdr_ack = 1'b1; sdr_data = 16'hDEAD;
            end
        end
        check("abort:no_early_dtack", early_dtack, 0);
        check("abort:req_held", req_hi, 6);
        as_n = 1'b1;
        step();
        check("abort:release", dtack_n, 1);
    endtask

    task automatic reset_test();
        as_n = 1'b0; slow_cs = 1'b1; rw = 1'b1; fast_cs = 1'b0; sdr_ack = 1'b0;
        for (int n = 0; n < 4; n++) step();
        check("rst:req_before", sdr_req, 1);
        #2;
        reset = 1'b1;
        as_n = 1'b1;
        #1;
        check("rst:dtack_async", dtack_n, 1);
        check("rst:req_async", sdr_req, 0);
        check("rst:din_async", cpu_din, 0);
        check("rst:timeout_async", timeout, 0);
        step();
        step();
        #2;
        reset = 1'b0;
        step();
        run_txn("rst_fast", 1'b1, 1'b0, 1'b1, 16'h1234, 16'h0, 1'b0, 0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; as_n = 1'b1; rw = 1'b1; fast_cs = 1'b0; slow_cs = 1'b0;
        fast_data = 16'h0; sdr_ack = 1'b0; sdr_data = 16'h0;
        step();
        step();
        check("reset:dtack_n", dtack_n, 1);
        check("reset:sdr_req", sdr_req, 0);
        check("reset:cpu_din", cpu_din, 0);
        check("reset:timeout", timeout, 0);
        #2;
        reset = 1'b0;
        step();

        run_txn("fast_read",   1'b1, 1'b0, 1'b1, 16'h1234, 16'h0,    1'b0, 0, 2);
        run_txn("rom_read",    1'b0, 1'b1, 1'b1, 16'h0,    16'hBEEF, 1'b1, 5, 1);
        run_txn("rom_timeout", 1'b0, 1'b1, 1'b1, 16'h0,    16'h0,    1'b0, 0, 1);
        run_txn("unmapped",    1'b0, 1'b0, 1'b1, 16'h5555, 16'h0,    1'b0, 0, 0);
        run_txn("rom_write",   1'b0, 1'b1, 1'b0, 16'h7777, 16'h0,    1'b1, 2, 0);
        run_txn("both_cs",     1'b1, 1'b1, 1'b1, 16'h1111, 16'hCAFE, 1'b1, 3, 0);
        run_txn("ack_at_to",   1'b0, 1'b1, 1'b1, 16'h0,    16'h4242, 1'b1, TO, 0);

        // Stray ack while idle must not start anything.
        sdr_ack = 1'b1;
        step();
        sdr_ack = 1'b0;
        step();
        check("stray_ack:req", sdr_req, 0);
        check("stray_ack:dtack", dtack_n, 1);

        abort_test();

        for (int i = 0; i < 80; i++) begin
            bit f, s, r, a;
            int gap;
            f = 1'($urandom_range(0, 1));
            s = 1'($urandom_range(0, 1));
            r = 1'($urandom_range(0, 1));
            a = ($urandom_range(0, 3) != 0);
            run_txn("rand", f, s, r, 16'($urandom), 16'($urandom), a,
                    int'($urandom_range(1, 11)), int'($urandom_range(0, 3)));
            gap = int'($urandom_range(0, 2));
            for (int g = 0; g < gap; g++) step();
        end

        reset_test();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
